// File: rtl/ringbuf_rx_deframer.sv
// Serial deframer: hunts for SYNC_PATTERN on strobed rxda, then packs FRAME_WORDS words into an output FIFO.
// Latency: last (or parity) bit sampled at edge N -> FIFO write at N+1 -> data_valid after N+1.
// Backpressure: valid/ready drain; a push into a full FIFO without a pop is dropped and sets sticky overflow.
// Optional parity bit per word: define RINGBUF_RX_PARITY_EN.

module ringbuf_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && not_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_push   = push && (!full || do_pop);
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module ringbuf_rx_deframer #(
  parameter int                  WORD_WIDTH   = 8,
  parameter logic [WORD_WIDTH-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                  FRAME_WORDS  = 4,
  parameter int                  FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rxda,
  input  logic                  outstrobe,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  parity_err,
  output logic                  locked,
  output logic                  overflow
);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int CW = $clog2(FRAME_WORDS + 1);
`ifdef RINGBUF_RX_PARITY_EN
  localparam int FW = WORD_WIDTH + 1;
`else
  localparam int FW = WORD_WIDTH;
`endif

  // LAST: final word's push is pending; sampling already behaves as HUNT.
  typedef enum logic [1:0] {HUNT, DATA, PARITY, LAST} state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] hunt_reg, hunt_nxt, hunt_shift;
  logic [WORD_WIDTH-1:0] word_reg, word_nxt, word_shift;
  logic [BW-1:0]         bit_cnt, bit_nxt;
  logic [CW-1:0]         word_cnt, wcnt_nxt;
  logic                  push_pend, push_nxt;
  logic [FW-1:0]         push_dat, pdat_nxt, done_dat;
  logic                  word_done;
  logic [FW-1:0]         fifo_head;
  logic                  fifo_full;

  assign hunt_shift = {hunt_reg[WORD_WIDTH-2:0], rxda};
  assign word_shift = {word_reg[WORD_WIDTH-2:0], rxda};

  always_comb begin
    state_nxt = state;
    hunt_nxt  = hunt_reg;
    word_nxt  = word_reg;
    bit_nxt   = bit_cnt;
    wcnt_nxt  = word_cnt;
    push_nxt  = 1'b0;
    pdat_nxt  = push_dat;
    word_done = 1'b0;
    done_dat  = '0;
    case (state)
      HUNT, LAST: begin
        if (state == LAST) state_nxt = HUNT;
        if (outstrobe) begin
          hunt_nxt = hunt_shift;
          if (hunt_shift == SYNC_PATTERN) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            wcnt_nxt  = '0;
          end
        end
      end
      DATA: begin
        if (outstrobe) begin
          word_nxt = word_shift;
          bit_nxt  = bit_cnt + BW'(1);
          if (bit_cnt == BW'(WORD_WIDTH - 1)) begin
            bit_nxt = '0;
`ifdef RINGBUF_RX_PARITY_EN
            state_nxt = PARITY;
`else
            word_done = 1'b1;
            done_dat  = word_shift;
`endif
          end
        end
      end
      PARITY: begin
`ifdef RINGBUF_RX_PARITY_EN
        if (outstrobe) begin
          word_done = 1'b1;
          done_dat  = {^{word_reg, rxda}, word_reg};
        end
`else
        state_nxt = HUNT;
`endif
      end
      default: state_nxt = HUNT;
    endcase
    if (word_done) begin
      push_nxt = 1'b1;
      pdat_nxt = done_dat;
      wcnt_nxt = word_cnt + CW'(1);
      if (word_cnt == CW'(FRAME_WORDS - 1)) begin
        state_nxt = LAST;
        hunt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hunt_reg  <= '0;
      word_reg  <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      push_pend <= 1'b0;
      push_dat  <= '0;
      overflow  <= 1'b0;
    end else begin
      hunt_reg  <= hunt_nxt;
      word_reg  <= word_nxt;
      bit_cnt   <= bit_nxt;
      word_cnt  <= wcnt_nxt;
      push_pend <= push_nxt;
      push_dat  <= pdat_nxt;
      if (push_pend && fifo_full && !data_ready) overflow <= 1'b1;
    end
  end

  ringbuf_rx_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_pend),
    .push_dat  (push_dat),
    .pop       (data_ready),
    .head      (fifo_head),
    .not_empty (data_valid),
    .full      (fifo_full)
  );

  assign locked = (state != HUNT);

`ifdef RINGBUF_RX_PARITY_EN
  assign data_out   = fifo_head[WORD_WIDTH-1:0];
  assign parity_err = fifo_head[WORD_WIDTH];
`else
  assign data_out   = fifo_head;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_ringbuf_rx_deframer.sv
// Directed bench for ringbuf_rx_deframer: sync hunt, frame decode, FIFO overflow, async reset, optional parity.
module tb_ringbuf_rx_deframer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rxda = 1'b0;
  logic       outstrobe = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, parity_err, locked, overflow;

  int         errors = 0;
  int         checks = 0;
  logic [8:0] got_q[$];

  always #5 clock = ~clock;

  ringbuf_rx_deframer #(
    .WORD_WIDTH(8), .SYNC_PATTERN(8'hA5), .FRAME_WORDS(4), .FIFO_DEPTH(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rxda       (rxda),
    .outstrobe  (outstrobe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .parity_err (parity_err),
    .locked     (locked),
    .overflow   (overflow)
  );

  // Words leaving the FIFO, captured mid-cycle ahead of the popping edge.
  always @(negedge clock)
    if (reset && data_valid && data_ready) got_q.push_back({parity_err, data_out});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rxda = b;
    outstrobe = 1'b1;
    tick(1);
    outstrobe = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int gap);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap > 0) tick(gap);
    end
  endtask

  // Data word, followed by a correct even-parity bit when parity is built in.
  task automatic send_data(input logic [7:0] w);
    send_word(w, 0);
`ifdef RINGBUF_RX_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic check_q(input string tag, input logic [31:0] ew);
    check({tag, "_cnt"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, {24'd0, ew[31-8*i -: 8]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst_dout", data_out, 0);
    check("rst_vld", data_valid, 0);
    check("rst_perr", parity_err, 0);
    check("rst_lock", locked, 0);
    check("rst_ovf", overflow, 0);
    tick(2);
    reset = 1'b1;
    tick(1);

    // Basic frame with consumer always ready
    data_ready = 1'b1;
    got_q.delete();
    send_word(8'hA5, 0);
    check("t2_lock", locked, 1);
    send_data(8'h3C);
    send_data(8'hC3);
    send_data(8'h00);
    send_data(8'hFF);
    check("t2_lock_tail", locked, 1);
    check("t2_lat_vld0", data_valid, 0);
    tick(1);
    check("t2_lat_vld1", data_valid, 1);
    check("t2_lat_dout", data_out, 8'hFF);
    check("t2_unlock", locked, 0);
    tick(2);
    check_q("t2", 32'h3CC300FF);

    // Near-miss stream with idle gaps must not lock; later sync does
    got_q.delete();
    send_word(8'hA4, 2);
    send_word(8'h3C, 2);
    check("t3_nolock", locked, 0);
    check("t3_novld", data_valid, 0);
    send_word(8'hA5, 1);
    check("t3_lock", locked, 1);
    send_data(8'h01);
    send_data(8'h02);
    send_data(8'h03);
    send_data(8'h04);
    tick(3);
    check_q("t3", 32'h01020304);
    check("t3_unlock", locked, 0);

    // Overflow: full FIFO drops the next frame's first word
    data_ready = 1'b0;
    got_q.delete();
    send_word(8'hA5, 0);
    send_data(8'h11);
    send_data(8'h22);
    send_data(8'h33);
    send_data(8'h44);
    tick(1);
    check("t4_vld", data_valid, 1);
    check("t4_head", data_out, 8'h11);
    check("t4_ovf0", overflow, 0);
    send_word(8'hA5, 0);
    send_data(8'h55);
    tick(1);
    check("t4_ovf1", overflow, 1);
    check("t4_head_kept", data_out, 8'h11);
    check("t4_lock", locked, 1);
    data_ready = 1'b1;
    tick(6);
    check_q("t4", 32'h11223344);
    check("t4_empty", data_valid, 0);

    // Async reset mid-activity with FIFO occupied and overflow set
    data_ready = 1'b0;
    send_data(8'h66);
    send_data(8'h77);
    send_data(8'h88);
    tick(1);
    check("t1_pre_vld", data_valid, 1);
    check("t1_pre_head", data_out, 8'h66);
    check("t1_pre_unlock", locked, 0);
    send_word(8'hA5, 0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t1_pre_lock", locked, 1);
    #2 reset = 1'b0;
    #1;
    check("t1_dout", data_out, 0);
    check("t1_vld", data_valid, 0);
    check("t1_lock", locked, 0);
    check("t1_ovf", overflow, 0);
    check("t1_perr", parity_err, 0);
    tick(1);
    reset = 1'b1;
    data_ready = 1'b1;
    got_q.delete();
    tick(5);
    check("t1_post_vld", data_valid, 0);
    check("t1_post_cnt", got_q.size(), 0);

    // Reset pulse partway through a data word, then a clean frame
    got_q.delete();
    send_word(8'hA5, 0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("t5_pre_lock", locked, 1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    check("t5_lock", locked, 0);
    check("t5_vld", data_valid, 0);
    send_word(8'hA5, 0);
    send_data(8'h5A);
    send_data(8'h69);
    send_data(8'h96);
    send_data(8'hF0);
    tick(3);
    check_q("t5", 32'h5A6996F0);

`ifdef RINGBUF_RX_PARITY_EN
    // Parity: 3C has four ones, so a 1 parity bit is an error and 0 is clean
    data_ready = 1'b0;
    got_q.delete();
    send_word(8'hA5, 0);
    send_word(8'h3C, 0);
    send_bit(1'b1);
    tick(1);
    check("t6_dout_a", data_out, 8'h3C);
    check("t6_perr_a", parity_err, 1);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("t6_drained", data_valid, 0);
    send_word(8'h3C, 0);
    send_bit(1'b0);
    tick(1);
    check("t6_dout_b", data_out, 8'h3C);
    check("t6_perr_b", parity_err, 0);
    data_ready = 1'b1;
    send_data(8'h81);
    send_data(8'h7E);
    tick(3);
    check("t6_cnt", got_q.size(), 4);
    check("t6_q0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h13C);
    check("t6_q1", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'h03C);
    check("t6_q2", (got_q.size() > 2) ? 32'(got_q[2]) : 32'hDEAD, 32'h081);
    check("t6_q3", (got_q.size() > 3) ? 32'(got_q[3]) : 32'hDEAD, 32'h07E);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
